insmem_loader: RTL and testbench

//  Boot-time program loader: the write side of the instruction memory. Accepts a

---
 rtl/insmem_loader_pkg.sv | 15 +
 rtl/insmem_loader_if.sv | 24 ++
 rtl/insmem_byte_packer.sv | 41 ++++
 rtl/insmem_loader.sv | 139 +++++++++++++
 tb/tb_insmem_loader.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/insmem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction store.
package insmem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned INS_BYTES           = 4;
  localparam int unsigned DEPTH_BYTES_DEFAULT = 80;

endpackage

// File: rtl/insmem_loader_if.sv
// Byte-stream input and word-write port of the instruction-memory loader.
interface insmem_loader_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  // master is the loader; slave is the byte source plus the instruction store
  modport master (
    input  byte_valid, byte_data,
    output byte_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output byte_valid, byte_data,
    input  byte_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/insmem_byte_packer.sv
// Assembles little-endian bytes into a 32-bit instruction word, one lane per beat.
module insmem_byte_packer
  import insmem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_beat,
  input  logic [7:0]  i_byte_data,
  output logic [31:0] o_word,
  output logic        o_word_full
);

  localparam int CNT_W = $clog2(INS_BYTES);

  logic [CNT_W-1:0] r_byte_cnt;
  logic [31:0]      r_word;
  logic [31:0]      w_word;

  // The word includes the byte of the current beat so the completing beat can be written straight out
  always_comb begin
    w_word = r_word;
    if (i_beat) begin
      w_word[{r_byte_cnt, 3'b000} +: 8] = i_byte_data;
    end
  end

  assign o_word      = w_word;
  assign o_word_full = i_beat && (r_byte_cnt == CNT_W'(INS_BYTES - 1));

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_byte_cnt <= '0;
      r_word     <= '0;
    end else if (i_beat) begin
      r_byte_cnt <= r_byte_cnt + 1'b1;
      r_word     <= w_word;
    end
  end

endmodule

// File: rtl/insmem_loader.sv
// Boot-time program loader: packs a byte stream into words, writes them from address 0
// and holds the core in reset until the requested number of words has been written.
module insmem_loader
  import insmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEFAULT,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [7:0]            i_len_words,
  insmem_loader_if.master       bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error,
  output logic                  o_cpu_hold
);

  loader_state_t     r_state;
  logic [7:0]        r_len;
  logic [7:0]        r_word_cnt;
  logic              r_byte_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic              r_cpu_hold;

  logic [9:0]        w_len_bytes;
  logic              w_too_long;
  logic              w_accept;
  logic              w_beat;
  logic [7:0]        w_word_cnt_nxt;
  logic [31:0]       w_word;
  logic              w_word_full;

  // 10-bit product covers 255 words * 4 without wrapping
  assign w_len_bytes    = {i_len_words, 2'b00};
  assign w_too_long     = (32'(w_len_bytes) > DEPTH_BYTES);
  assign w_accept       = i_start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_beat         = bus.byte_valid && r_byte_ready;
  assign w_word_cnt_nxt = r_word_cnt + 8'd1;

  insmem_byte_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_accept),
    .i_beat      (w_beat),
    .i_byte_data (bus.byte_data),
    .o_word      (w_word),
    .o_word_full (w_word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_ready <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_cpu_hold   <= 1'b1;
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: begin
          if (w_accept) begin
            if (w_too_long) begin
              r_state    <= ERR;
              r_error    <= 1'b1;
              r_done     <= 1'b0;
              r_busy     <= 1'b0;
              r_cpu_hold <= 1'b1;
            end else if (i_len_words == 8'd0) begin
              r_state    <= DONE;
              r_error    <= 1'b0;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_cpu_hold <= 1'b0;
            end else begin
              r_state      <= RECV;
              r_len        <= i_len_words;
              r_word_cnt   <= '0;
              r_byte_ready <= 1'b1;
              r_error      <= 1'b0;
              r_done       <= 1'b0;
              r_busy       <= 1'b1;
              r_cpu_hold   <= 1'b1;
            end
          end
        end
        RECV: begin
          if (w_word_full) begin
            r_state      <= WRITE;
            r_byte_ready <= 1'b0;
            r_wr_en      <= 1'b1;
            r_wr_addr    <= ADDR_W'({r_word_cnt, 2'b00});
            r_wr_data    <= w_word;
          end
        end
        WRITE: begin
          r_word_cnt <= w_word_cnt_nxt;
          if (w_word_cnt_nxt == r_len) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state      <= RECV;
            r_byte_ready <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_byte_ready <= 1'b0;
          r_busy       <= 1'b0;
          r_cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.byte_ready = r_byte_ready;
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_error        = r_error;
  assign o_cpu_hold     = r_cpu_hold;

endmodule

// File: tb/tb_insmem_loader.sv
// Scoreboard bench for insmem_loader: stimulus queues expected word writes, a monitor
// pops and compares them whenever the loader strobes wr_en.
module tb_insmem_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_start;
  logic [7:0] i_len_words;
  logic       o_busy;
  logic       o_done;
  logic       o_error;
  logic       o_cpu_hold;

  insmem_loader_if #(.ADDR_W(32)) bus ();

  insmem_loader #(
    .DEPTH_BYTES (80),
    .ADDR_W      (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_len_words (i_len_words),
    .bus         (bus),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_error     (o_error),
    .o_cpu_hold  (o_cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         expQ[$];
  wr_t         expEntry;
  int          checks     = 0;
  int          errors     = 0;
  int          writeCount = 0;
  logic [31:0] lastAddr   = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued expectation
  always @(negedge clk) begin
    if (bus.wr_en === 1'b1) begin
      writeCount++;
      lastAddr = bus.wr_addr;
      checkOutput("byte_ready_during_write", 32'(bus.byte_ready), 32'd0);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        expEntry = expQ.pop_front();
        checkOutput("wr_addr", bus.wr_addr, expEntry.addr);
        checkOutput("wr_data", bus.wr_data, expEntry.data);
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] len);
    i_start     = 1'b1;
    i_len_words = len;
    @(posedge clk);
    #1;
    i_start     = 1'b0;
    i_len_words = 8'd0;
  endtask

  task automatic sendByte(input logic [7:0] b, input int gap);
    bit accepted;
    accepted = 1'b0;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) begin
        accepted = 1'b1;
        break;
      end
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("[TB] FAIL byte_accept_timeout: got byte_ready 0 expected 1 within 200 cycles");
      bus.byte_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sendWord(input logic [31:0] w, input int maxGap);
    for (int k = 0; k < 4; k++) begin
      sendByte(w[8*k +: 8], (maxGap == 0) ? 0 : int'($urandom_range(0, maxGap)));
    end
  endtask

  task automatic waitDone(input string name);
    for (int i = 0; i < 30; i++) begin
      if (o_done === 1'b1) break;
      @(posedge clk);
      #1;
    end
    checkOutput(name, 32'(o_done), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_byte_ready"}, 32'(bus.byte_ready), 32'd0);
    checkOutput({tag, "_wr_en"},      32'(bus.wr_en),      32'd0);
    checkOutput({tag, "_wr_addr"},    bus.wr_addr,         32'd0);
    checkOutput({tag, "_wr_data"},    bus.wr_data,         32'd0);
    checkOutput({tag, "_busy"},       32'(o_busy),         32'd0);
    checkOutput({tag, "_done"},       32'(o_done),         32'd0);
    checkOutput({tag, "_error"},      32'(o_error),        32'd0);
    checkOutput({tag, "_cpu_hold"},   32'(o_cpu_hold),     32'd1);
  endtask

  logic [7:0]  t1Bytes [4] = '{8'h93, 8'h00, 8'hA0, 8'h00};
  logic [7:0]  t2Bytes [8] = '{8'h13, 8'h01, 8'h40, 8'h01, 8'hB3, 8'h01, 8'h11, 8'h00};
  logic [31:0] word;
  int          wc;

  initial begin
    rst            = 1'b1;
    i_start        = 1'b0;
    i_len_words    = 8'd0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst = 1'b0;

    $display("[TB] single word, valid held high");
    wc = writeCount;
    expQ.push_back('{32'd0, 32'h00A00093});
    applyStimulus(8'd1);
    checkOutput("t1_busy", 32'(o_busy), 32'd1);
    checkOutput("t1_byte_ready", 32'(bus.byte_ready), 32'd1);
    foreach (t1Bytes[i]) sendByte(t1Bytes[i], 0);
    bus.byte_valid = 1'b0;
    waitDone("t1_done");
    checkOutput("t1_cpu_hold", 32'(o_cpu_hold), 32'd0);
    checkOutput("t1_busy_after", 32'(o_busy), 32'd0);
    checkOutput("t1_write_count", 32'(writeCount - wc), 32'd1);

    $display("[TB] two words with random valid gaps");
    wc = writeCount;
    expQ.push_back('{32'd0, 32'h01400113});
    expQ.push_back('{32'd4, 32'h001101B3});
    applyStimulus(8'd2);
    foreach (t2Bytes[i]) sendByte(t2Bytes[i], int'($urandom_range(0, 3)));
    bus.byte_valid = 1'b0;
    waitDone("t2_done");
    checkOutput("t2_write_count", 32'(writeCount - wc), 32'd2);
    checkOutput("t2_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] oversize length rejected, then full-capacity load");
    wc = writeCount;
    applyStimulus(8'd21);
    checkOutput("t3_error", 32'(o_error), 32'd1);
    checkOutput("t3_cpu_hold", 32'(o_cpu_hold), 32'd1);
    checkOutput("t3_done", 32'(o_done), 32'd0);
    checkOutput("t3_byte_ready", 32'(bus.byte_ready), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t3_no_write", 32'(writeCount - wc), 32'd0);
    applyStimulus(8'd20);
    checkOutput("t3_error_cleared", 32'(o_error), 32'd0);
    checkOutput("t3_busy", 32'(o_busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      word = {8'h5A, 8'(i), 8'hC3, 8'(3 * i + 1)};
      expQ.push_back('{32'(4 * i), word});
      sendWord(word, 0);
    end
    bus.byte_valid = 1'b0;
    waitDone("t3_done_full");
    checkOutput("t3_write_count", 32'(writeCount - wc), 32'd20);
    checkOutput("t3_last_addr", lastAddr, 32'd76);

    $display("[TB] zero length, then start pulses during a load");
    wc = writeCount;
    applyStimulus(8'd0);
    checkOutput("t4_done_len0", 32'(o_done), 32'd1);
    checkOutput("t4_cpu_hold_len0", 32'(o_cpu_hold), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t4_no_write_len0", 32'(writeCount - wc), 32'd0);
    applyStimulus(8'd3);
    for (int w = 0; w < 3; w++) begin
      word = {8'hA0 + 8'(w), 8'h1B, 8'h2C, 8'h3D + 8'(w)};
      expQ.push_back('{32'(4 * w), word});
      sendByte(word[7:0], 0);
      bus.byte_valid = 1'b0;
      applyStimulus(8'd7);
      sendByte(word[15:8], 0);
      sendByte(word[23:16], 0);
      sendByte(word[31:24], 0);
      bus.byte_valid = 1'b0;
      applyStimulus(8'd7);
    end
    waitDone("t4_done_len3");
    checkOutput("t4_write_count", 32'(writeCount - wc), 32'd3);
    checkOutput("t4_queue_empty", 32'(expQ.size()), 32'd0);

    $display("[TB] reset in the middle of a word");
    applyStimulus(8'd1);
    sendByte(8'h11, 0);
    sendByte(8'h22, 0);
    bus.byte_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkResetValues("t5_reset");
    rst = 1'b0;
    wc = writeCount;
    expQ.push_back('{32'd0, 32'hCAFEF00D});
    applyStimulus(8'd1);
    sendWord(32'hCAFEF00D, 0);
    bus.byte_valid = 1'b0;
    waitDone("t5_done");
    checkOutput("t5_write_count", 32'(writeCount - wc), 32'd1);

    $display("[TB] long source stall");
    wc = writeCount;
    expQ.push_back('{32'd0, 32'h12345678});
    applyStimulus(8'd1);
    sendByte(8'h78, 0);
    sendByte(8'h56, 0);
    bus.byte_valid = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("t6_busy", 32'(o_busy), 32'd1);
    checkOutput("t6_byte_ready", 32'(bus.byte_ready), 32'd1);
    checkOutput("t6_done", 32'(o_done), 32'd0);
    checkOutput("t6_cpu_hold", 32'(o_cpu_hold), 32'd1);
    checkOutput("t6_no_write", 32'(writeCount - wc), 32'd0);
    sendByte(8'h34, 0);
    sendByte(8'h12, 0);
    bus.byte_valid = 1'b0;
    waitDone("t6_done_after");
    checkOutput("t6_write_count", 32'(writeCount - wc), 32'd1);
    checkOutput("final_queue_empty", 32'(expQ.size()), 32'd0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
